// File: rtl/key_filter_array.sv
// Multi-channel key debouncer: per-channel synchroniser, four-state debounce FSM,
// and registered press / release / long-press / auto-repeat pulses plus debounced level.
module key_filter_array #(
  parameter int unsigned KEY_W     = 4,
  parameter int unsigned DB_MAX    = 1_000_000,
  parameter int unsigned LONG_MAX  = 50_000_000,
  parameter int unsigned REP_MAX   = 10_000_000,
  parameter int unsigned REPEAT_EN = 1,
  parameter int unsigned CNT_W     = 26
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat,
  output logic [KEY_W-1:0] key_level
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    DOWN = 4'b0010,
    HOLD = 4'b0100,
    UP   = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DB_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_MAX - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REP_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    logic [2:0]       key_r;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             long_done, long_done_nxt;
    logic             press_c, release_c, long_c, repeat_c, level_c;
    logic             press_q, release_q, long_q, repeat_q, level_q;
    logic             level, prev, fall, rise, db_tc;

    assign level = key_r[1];
    assign prev  = key_r[2];
    assign fall  = prev & ~level;
    assign rise  = ~prev & level;
    assign db_tc = (db_cnt == DB_TC);

    // Terminal count is tested ahead of the edges so it wins a same-cycle tie.
    always_comb begin
      state_nxt = state;
      press_c   = 1'b0;
      release_c = 1'b0;
      case (state)
        IDLE: if (fall) state_nxt = DOWN;
        DOWN: begin
          if (db_tc) begin
            state_nxt = HOLD;
            press_c   = 1'b1;
          end else if (rise) begin
            state_nxt = IDLE;
          end
        end
        HOLD: if (rise) state_nxt = UP;
        UP: begin
          if (db_tc) begin
            state_nxt = IDLE;
            release_c = 1'b1;
          end else if (fall) begin
            state_nxt = HOLD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Debounce, long-press and repeat counters.
    always_comb begin
      db_cnt_nxt    = '0;
      hold_cnt_nxt  = hold_cnt;
      rep_cnt_nxt   = rep_cnt;
      long_done_nxt = long_done;
      long_c        = 1'b0;
      repeat_c      = 1'b0;
      level_c       = (state_nxt == HOLD) || (state_nxt == UP);

      if (((state == DOWN) || (state == UP)) && (state_nxt == state))
        db_cnt_nxt = db_cnt + CNT_ONE;

      if ((state == IDLE) || (state == DOWN)) begin
        hold_cnt_nxt = '0;
      end else if (state == HOLD) begin
        if (hold_cnt == LONG_TC) begin
          if (!long_done) begin
            long_c        = 1'b1;
            long_done_nxt = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_ONE;
        end
      end

      if (REPEAT_EN != 0) begin
        if ((state == IDLE) || (state_nxt == IDLE)) begin
          rep_cnt_nxt = '0;
        end else if ((state == HOLD) && long_done) begin
          if (rep_cnt == REP_TC) begin
            repeat_c    = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + CNT_ONE;
          end
        end
      end

      if (state_nxt == IDLE)
        long_done_nxt = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        key_r     <= 3'b111;
        state     <= IDLE;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        long_done <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        key_r     <= {key_r[1:0], key_in[i]};
        state     <= state_nxt;
        db_cnt    <= db_cnt_nxt;
        hold_cnt  <= hold_cnt_nxt;
        rep_cnt   <= rep_cnt_nxt;
        long_done <= long_done_nxt;
        press_q   <= press_c;
        release_q <= release_c;
        long_q    <= long_c;
        repeat_q  <= repeat_c;
        level_q   <= level_c;
      end
    end

    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
    assign key_level[i]   = level_q;
  end

endmodule

// File: tb/tb_key_filter_array.sv
// Scoreboard bench for key_filter_array: directed key waveforms push expected pulse
// vectors; a negedge monitor pops and compares whenever any pulse output is active.
module tb_key_filter_array;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] key_in    = 2'b11;
  logic [1:0] key_press, key_release, key_long, key_repeat, key_level;
  logic [1:0] nr_press, nr_release, nr_long, nr_repeat, nr_level;

  key_filter_array #(
    .KEY_W(2), .DB_MAX(8), .LONG_MAX(32), .REP_MAX(8), .REPEAT_EN(1), .CNT_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_repeat(key_repeat), .key_level(key_level)
  );

  key_filter_array #(
    .KEY_W(2), .DB_MAX(8), .LONG_MAX(32), .REP_MAX(8), .REPEAT_EN(0), .CNT_W(8)
  ) dut_nr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_press(nr_press), .key_release(nr_release), .key_long(nr_long),
    .key_repeat(nr_repeat), .key_level(nr_level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [1:0] p, r, l, rp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0, nvec = 0, errs = 0, nr_rep_hits = 0, nr_long_hits = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every active pulse cycle must match the next scoreboard entry.
  always @(negedge sys_clk) begin
    if (nr_repeat != 2'b00) nr_rep_hits++;
    if (nr_long != 2'b00) nr_long_hits++;
    if ((key_press | key_release | key_long | key_repeat) != 2'b00) begin
      nvec++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_pulse: got cyc=%0d p=%b r=%b l=%b rp=%b, required no pulse",
                 cyc, key_press, key_release, key_long, key_repeat);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.p !== key_press || e.r !== key_release ||
            e.l !== key_long || e.rp !== key_repeat) begin
          errs++;
          $display("FAIL pulse_vec: got cyc=%0d p=%b r=%b l=%b rp=%b, required cyc=%0d p=%b r=%b l=%b rp=%b",
                   cyc, key_press, key_release, key_long, key_repeat,
                   e.cyc, e.p, e.r, e.l, e.rp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] l, input logic [1:0] rp);
    exp_t x;
    x.cyc = c; x.p = p; x.r = r; x.l = l; x.rp = rp;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
    nvec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %b, required %b at cyc %0d", nm, act, req, cyc);
    end
  endtask

  int t0;

  initial begin
    tick(3);
    chk("rst_press",   key_press,   2'b00);
    chk("rst_release", key_release, 2'b00);
    chk("rst_long",    key_long,    2'b00);
    chk("rst_repeat",  key_repeat,  2'b00);
    chk("rst_level",   key_level,   2'b00);
    sys_rst_n = 1'b1;
    tick(4);

    // Clean press on ch0, held 20 cycles, then release.
    t0 = cyc + 1;
    push(t0 + 10, 2'b01, 2'b00, 2'b00, 2'b00);
    push(t0 + 30, 2'b00, 2'b01, 2'b00, 2'b00);
    key_in = 2'b10;
    tick(10);
    chk("clean_level_before", key_level, 2'b00);
    tick(1);
    chk("clean_level_after", key_level, 2'b01);
    tick(9);
    key_in = 2'b11;
    tick(16);

    // Bounce: low 3, high 2, then steady low.
    t0 = cyc + 1;
    push(t0 + 15, 2'b01, 2'b00, 2'b00, 2'b00);
    push(t0 + 40, 2'b00, 2'b01, 2'b00, 2'b00);
    key_in = 2'b10;
    tick(3);
    key_in = 2'b11;
    tick(2);
    key_in = 2'b10;
    tick(25);
    key_in = 2'b11;
    tick(15);

    // Long hold with auto-repeat, released before the fifth repeat.
    t0 = cyc + 1;
    push(t0 + 10, 2'b01, 2'b00, 2'b00, 2'b00);
    push(t0 + 42, 2'b00, 2'b00, 2'b01, 2'b00);
    push(t0 + 50, 2'b00, 2'b00, 2'b00, 2'b01);
    push(t0 + 58, 2'b00, 2'b00, 2'b00, 2'b01);
    push(t0 + 66, 2'b00, 2'b00, 2'b00, 2'b01);
    push(t0 + 74, 2'b00, 2'b00, 2'b00, 2'b01);
    push(t0 + 87, 2'b00, 2'b01, 2'b00, 2'b00);
    key_in = 2'b10;
    tick(77);
    key_in = 2'b11;
    tick(15);

    // Release glitch after key_long: UP->HOLD, no extra pulses, repeat pauses.
    t0 = cyc + 1;
    push(t0 + 10, 2'b01, 2'b00, 2'b00, 2'b00);
    push(t0 + 42, 2'b00, 2'b00, 2'b01, 2'b00);
    push(t0 + 53, 2'b00, 2'b00, 2'b00, 2'b01);
    push(t0 + 66, 2'b00, 2'b01, 2'b00, 2'b00);
    key_in = 2'b10;
    tick(44);
    key_in = 2'b11;
    tick(3);
    key_in = 2'b10;
    tick(2);
    chk("glitch_level_in_up", key_level, 2'b01);
    tick(7);
    key_in = 2'b11;
    tick(15);

    // Both keys together, then reset mid-hold with keys still held.
    t0 = cyc + 1;
    push(t0 + 10, 2'b11, 2'b00, 2'b00, 2'b00);
    push(t0 + 27, 2'b11, 2'b00, 2'b00, 2'b00);
    push(t0 + 39, 2'b00, 2'b11, 2'b00, 2'b00);
    key_in = 2'b00;
    tick(15);
    chk("both_level", key_level, 2'b11);
    sys_rst_n = 1'b0;
    tick(1);
    chk("midrst_level",   key_level,   2'b00);
    chk("midrst_press",   key_press,   2'b00);
    chk("midrst_release", key_release, 2'b00);
    tick(1);
    sys_rst_n = 1'b1;
    tick(12);
    chk("post_rst_level", key_level, 2'b11);
    key_in = 2'b11;
    tick(15);

    tick(5);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      nvec++;
      errs++;
      $display("FAIL missing_pulse: got nothing, required cyc=%0d p=%b r=%b l=%b rp=%b",
               e.cyc, e.p, e.r, e.l, e.rp);
    end
    nvec++;
    if (nr_rep_hits != 0) begin
      errs++;
      $display("FAIL norepeat_inst: got %0d repeat cycles, required 0", nr_rep_hits);
    end
    nvec++;
    if (nr_long_hits != 2) begin
      errs++;
      $display("FAIL norepeat_long: got %0d long pulses, required 2", nr_long_hits);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
